pll_cfg_seq: RTL and testbench

PLL_CFG_SEQ -- requirements
Module: pll_cfg_seq

---
 rtl/pll_cfg_pkg.sv | 9 +
 rtl/pll_cfg_seq_if.sv | 9 +
 rtl/pll_cfg_debounce.sv | 24 ++
 rtl/pll_cfg_seq.sv | 80 ++++++++
 tb/tb_pll_cfg_seq.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: register map, FSM states and default K words for the PLL reconfig sequencer
package pll_cfg_pkg;
  localparam logic [5:0] ADDR_MODE = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_K = 6'd7;
  localparam logic [31:0] K_NTSC_DEF = 32'd2537930535;
  localparam logic [31:0] K_PAL_DEF = 32'd2201376898;
  typedef enum logic [2:0] {IDLE, WAIT_LOCK, W_MODE, W_K, W_START, WAIT_DONE} state_t;
endpackage

// File: rtl/pll_cfg_seq_if.sv
// pll_cfg_seq_if: Avalon-MM write port toward the PLL reconfig core
interface pll_cfg_seq_if;
  logic [5:0] mgmt_address;
  logic mgmt_write;
  logic [31:0] mgmt_writedata;
  logic mgmt_waitrequest;
  modport master(output mgmt_address, mgmt_write, mgmt_writedata, input mgmt_waitrequest);
  modport slave(input mgmt_address, mgmt_write, mgmt_writedata, output mgmt_waitrequest);
endinterface

// File: rtl/pll_cfg_debounce.sv
// pll_cfg_debounce: 2-flop synchronizer plus stability filter of SETTLE+1 cycles
module pll_cfg_debounce #(
  parameter int SETTLE = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);
  localparam int W = $clog2(SETTLE + 2);
  logic [1:0] sync_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic db_q, db_d;
  // count consecutive cycles the synchronized input differs from the accepted value
  always_comb begin
    cnt_d = (sync_q[1] == db_q || cnt_q == W'(SETTLE)) ? '0 : cnt_q + W'(1);
    db_d = (sync_q[1] != db_q && cnt_q == W'(SETTLE)) ? sync_q[1] : db_q;
  end
  // synchronizer, counter and accepted value
  always_ff @(posedge clk or posedge rst)
    if (rst) {sync_q, cnt_q, db_q} <= '0;
    else {sync_q, cnt_q, db_q} <= {sync_q[0], din, cnt_d, db_d};
  assign dout = db_q;
endmodule

// File: rtl/pll_cfg_seq.sv
// pll_cfg_seq: reprograms the PLL fractional-K word whenever the debounced video standard changes
module pll_cfg_seq
  import pll_cfg_pkg::*;
#(
  parameter logic [31:0] K_NTSC = K_NTSC_DEF,
  parameter logic [31:0] K_PAL = K_PAL_DEF,
  parameter int SETTLE = 1023,
  parameter int TIMEOUT = 1048575
) (
  input  logic clk,
  input  logic rst,
  input  logic pal,
  input  logic pll_locked,
  pll_cfg_seq_if.master m,
  output logic busy,
  output logic mode_active,
  output logic cfg_done,
  output logic cfg_err
);
  state_t state_q, state_d;
  logic [1:0] lock_q;
  logic [19:0] cnt_q, cnt_d;
  logic pal_db, lock_s, wr_ok;
  logic target_q, target_d, mode_q, mode_d, done_q, done_d, err_q, err_d, busy_q;
  pll_cfg_debounce #(.SETTLE(SETTLE)) u_pal_db (.clk(clk), .rst(rst), .din(pal), .dout(pal_db));
  assign lock_s = lock_q[1];
  assign wr_ok = !m.mgmt_waitrequest;
  // next-state logic; a pal change mid-sequence is only seen again from IDLE
  always_comb begin
    state_d = state_q;
    target_d = target_q;
    mode_d = mode_q;
    done_d = 1'b0;
    err_d = err_q;
    cnt_d = (state_q == WAIT_DONE) ? cnt_q + 20'd1 : '0;
    case (state_q)
      IDLE: if (pal_db != mode_q) begin
        state_d = WAIT_LOCK;
        target_d = pal_db;
      end
      WAIT_LOCK: if (lock_s) state_d = W_MODE;
      W_MODE: if (wr_ok) state_d = W_K;
      W_K: if (wr_ok) state_d = W_START;
      W_START: if (wr_ok) state_d = WAIT_DONE;
      WAIT_DONE: if (wr_ok && lock_s) begin
        state_d = IDLE;
        mode_d = target_q;
        done_d = 1'b1;
        err_d = 1'b0;
      end else if (cnt_q == 20'(TIMEOUT)) begin
        state_d = IDLE;
        err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // bus outputs decode straight from the state so reset drops the strobe at once
  always_comb begin
    m.mgmt_write = state_q inside {W_MODE, W_K, W_START};
    m.mgmt_address = (state_q == W_K) ? ADDR_K : (state_q == W_START) ? ADDR_START : ADDR_MODE;
    m.mgmt_writedata = (state_q == W_K) ? (target_q ? K_PAL : K_NTSC) : '0;
  end
  // state, lock synchronizer and status registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      lock_q <= '0;
      cnt_q <= '0;
      {target_q, mode_q, done_q, err_q, busy_q} <= '0;
    end else begin
      state_q <= state_d;
      lock_q <= {lock_q[0], pll_locked};
      cnt_q <= cnt_d;
      {target_q, mode_q, done_q, err_q, busy_q} <= {target_d, mode_d, done_d, err_d, state_d != IDLE};
    end
  assign busy = busy_q;
  assign mode_active = mode_q;
  assign cfg_done = done_q;
  assign cfg_err = err_q;
endmodule

// File: tb/tb_pll_cfg_seq.sv
// tb_pll_cfg_seq: scoreboard of expected reconfig writes plus table-driven standard switches
module tb_pll_cfg_seq;
  import pll_cfg_pkg::*;
  localparam int TO = 300;
  localparam logic [31:0] KN = 32'd2537930535;
  localparam logic [31:0] KP = 32'd2201376898;
  typedef struct {logic [5:0] a; logic [31:0] d;} wr_t;
  typedef struct {logic pal; int stall; logic exp_mode;} vec_t;
  logic clk = 1'b0, rst = 1'b1, pal = 1'b0, pll_locked = 1'b1;
  logic busy, mode_active, cfg_done, cfg_err;
  pll_cfg_seq_if m();
  pll_cfg_seq #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .pal(pal), .pll_locked(pll_locked), .m(m),
    .busy(busy), .mode_active(mode_active), .cfg_done(cfg_done), .cfg_err(cfg_err)
  );
  int n_cmp = 0, n_bad = 0, cyc = 0, stall_n = 0, stall_cnt = 0, last_done = 0, start_done = 0;
  bit held = 0;
  logic [5:0] pa;
  logic [31:0] pd;
  wr_t q[$];
  wr_t e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic push_seq(logic t);
    q.push_back('{ADDR_MODE, 32'd0});
    q.push_back('{ADDR_K, t ? KP : KN});
    q.push_back('{ADDR_START, 32'd0});
  endtask
  // slave model: stall each write stall_n cycles, check hold stability, score completed writes
  always @(negedge clk) begin
    if (rst) begin
      m.mgmt_waitrequest = 1'b0;
      held = 0;
      stall_cnt = 0;
    end else begin
      m.mgmt_waitrequest = m.mgmt_write && stall_cnt < stall_n;
      if (m.mgmt_write) begin
        if (held) begin
          chk("hold_addr", 32'(m.mgmt_address), 32'(pa));
          chk("hold_data", m.mgmt_writedata, pd);
        end
        pa = m.mgmt_address;
        pd = m.mgmt_writedata;
        if (m.mgmt_waitrequest) begin
          held = 1;
          stall_cnt++;
        end else begin
          held = 0;
          stall_cnt = 0;
          chk("wr_expected", 32'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("wr_addr", 32'(m.mgmt_address), 32'(e.a));
            chk("wr_data", m.mgmt_writedata, e.d);
            if (e.a != ADDR_MODE) chk("wr_gap", cyc - last_done, stall_n + 1);
            if (e.a == ADDR_START) start_done = cyc;
          end
          last_done = cyc;
        end
      end
    end
  end
  task automatic wait_write(string nm, logic [5:0] a, int bound);
    int k = 0;
    while (!(m.mgmt_write && m.mgmt_address == a) && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_write_seen"}, 32'(m.mgmt_write && m.mgmt_address == a), 1);
  endtask
  task automatic wait_done(string nm, int bound, int q_left);
    int k = 0;
    while (!cfg_done && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_done_seen"}, 32'(cfg_done), 1);
    if (cfg_done) begin
      chk({nm, "_latency"}, cyc - start_done, 2);
      chk({nm, "_err_clr"}, 32'(cfg_err), 0);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_q_left"}, q.size(), q_left);
      @(negedge clk);
      chk({nm, "_pulse"}, 32'(cfg_done), 0);
    end
  endtask
  task automatic scan_quiet(string nm, int n);
    bit saw = 0;
    repeat (n) begin
      @(negedge clk);
      if (m.mgmt_write || busy || cfg_done) saw = 1;
    end
    chk(nm, 32'(saw), 0);
  endtask
  initial begin
    vec_t tv[4];
    int k;
    bit saw;
    tv[0] = '{pal: 1'b1, stall: 0, exp_mode: 1'b1};
    tv[1] = '{pal: 1'b0, stall: 3, exp_mode: 1'b0};
    tv[2] = '{pal: 1'b1, stall: 1, exp_mode: 1'b1};
    tv[3] = '{pal: 1'b0, stall: 0, exp_mode: 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mode", 32'(mode_active), 0);
    chk("rst_done", 32'(cfg_done), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_write", 32'(m.mgmt_write), 0);
    chk("rst_addr", 32'(m.mgmt_address), 0);
    chk("rst_data", m.mgmt_writedata, 0);
    rst = 1'b0;
    scan_quiet("idle_5000_quiet", 5000);
    chk("idle_mode", 32'(mode_active), 0);
    foreach (tv[i]) begin
      stall_n = tv[i].stall;
      pal = tv[i].pal;
      push_seq(tv[i].pal);
      wait_done($sformatf("vec%0d", i), 3000, 0);
      chk($sformatf("vec%0d_mode", i), 32'(mode_active), 32'(tv[i].exp_mode));
      repeat (5) @(negedge clk);
    end
    pal = 1'b1;
    repeat (500) @(negedge clk);
    pal = 1'b0;
    scan_quiet("glitch_quiet", 2000);
    chk("glitch_mode", 32'(mode_active), 0);
    stall_n = 0;
    pal = 1'b1;
    push_seq(1'b1);
    wait_write("tog", ADDR_K, 3000);
    pal = 1'b0;
    push_seq(1'b0);
    wait_done("tog1", 100, 3);
    chk("tog1_mode", 32'(mode_active), 1);
    wait_done("tog2", 3000, 0);
    chk("tog2_mode", 32'(mode_active), 0);
    stall_n = 3;
    pal = 1'b1;
    push_seq(1'b1);
    wait_write("to", ADDR_START, 3000);
    pll_locked = 1'b0;
    k = 0;
    saw = 0;
    while (!cfg_err && k < TO + 50) begin
      @(negedge clk);
      k++;
      if (cfg_done) saw = 1;
    end
    chk("to_err", 32'(cfg_err), 1);
    chk("to_time", cyc - start_done, TO + 2);
    chk("to_no_done", 32'(saw), 0);
    chk("to_mode", 32'(mode_active), 0);
    push_seq(1'b1);
    repeat (20) @(negedge clk);
    chk("retry_busy", 32'(busy), 1);
    chk("retry_wait_lock", 32'(m.mgmt_write), 0);
    chk("retry_err_held", 32'(cfg_err), 1);
    pll_locked = 1'b1;
    wait_done("retry", 200, 0);
    chk("retry_mode", 32'(mode_active), 1);
    stall_n = 1000;
    pal = 1'b0;
    push_seq(1'b0);
    wait_write("rmw", ADDR_MODE, 3000);
    #2 rst = 1'b1;
    #1 chk("rmw_write_drop", 32'(m.mgmt_write), 0);
    chk("rmw_busy", 32'(busy), 0);
    q.delete();
    stall_n = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    scan_quiet("rmw_quiet", 1500);
    chk("rmw_mode", 32'(mode_active), 0);
    rst = 1'b1;
    pal = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    push_seq(1'b1);
    wait_done("por_pal", 3000, 0);
    chk("por_pal_mode", 32'(mode_active), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
